pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, exception handler entry PC.
REQ-002 SHALL have parameter ERET_TYPE, default 32'h0000_000E, excepttype code meaning ERET (return to EPC).
REQ-003 SHALL have parameter WAIT_LIMIT, default 255, maximum cache-wait cycles before watchdog error.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  ID-stage stall request (load-use hazard).
- stallreq_ex  in  1  EX-stage stall request (multi-cycle op).
- icache_busy  in  1  I-cache miss in progress.
- dcache_busy  in  1  D-cache miss in progress.
- mem_excepttype  in  32  exception code from MEM stage; nonzero = exception.
- cp0_epc  in  32  current EPC from CP0.
- stall  out  6  per-stage hold: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect PC, valid only while flush=1.
- stall_cnt  out  16  total cycles with stall!=0, saturating.
- flush_cnt  out  8  total flush events, saturating.
- wait_err  out  1  sticky watchdog error.

Function
REQ-005 SHALL implement an FSM with states RUN, ICWAIT, DCWAIT and BLANK.
REQ-006 SHALL drive stall, flush and new_pc combinationally from the current state and inputs.
REQ-007 SHALL drive stall_cnt, flush_cnt and wait_err from registers.
REQ-008 SHALL in RUN apply the first matching row of this priority list:
- dcache_busy: stall=6'b011111, flush=0, next state DCWAIT.
- mem_excepttype!=0: flush=1, stall=0, next state BLANK.
- stallreq_ex: stall=6'b001111.
- stallreq_id: stall=6'b000111.
- icache_busy: stall=6'b000011, next state ICWAIT.
- otherwise: stall=0.
REQ-009 SHALL set new_pc=cp0_epc when flush=1 and mem_excepttype==ERET_TYPE, else new_pc=EXC_VECTOR when flush=1, else new_pc=0.
REQ-010 SHALL in DCWAIT hold stall=6'b011111 and flush=0 while dcache_busy=1, ignoring mem_excepttype and all other requests.
REQ-011 SHALL leave DCWAIT when dcache_busy=0 and evaluate REQ-008 in that same cycle; a held exception therefore flushes on the first non-busy cycle.
REQ-012 SHALL in ICWAIT hold stall at least 6'b000011, OR-ed with the stallreq_ex/stallreq_id patterns.
REQ-013 SHALL in ICWAIT give dcache_busy and nonzero mem_excepttype the same handling as in RUN.
REQ-014 SHALL, when an exception is taken in ICWAIT, abandon the I-cache wait (flush=1, next state BLANK).
REQ-015 SHALL leave ICWAIT for RUN when icache_busy=0.
REQ-016 SHALL in BLANK output stall=0 and flush=0, treat mem_excepttype as stale and ignore it, and return to RUN after exactly one cycle.
REQ-017 SHALL in BLANK honour dcache_busy (stall=6'b011111, next state DCWAIT).
REQ-018 SHALL assert flush for exactly one cycle per exception.
REQ-019 SHALL never assert flush and a nonzero stall in the same cycle.
REQ-020 SHALL count consecutive cycles spent in ICWAIT or DCWAIT with a 16-bit internal counter, cleared on entry to RUN or BLANK.
REQ-021 SHALL set wait_err when that counter exceeds WAIT_LIMIT; wait_err stays set until reset and does not alter stall behaviour.
REQ-022 SHALL increment stall_cnt each cycle stall!=0, saturating at 16'hFFFF.
REQ-023 SHALL increment flush_cnt each cycle flush=1, saturating at 8'hFF.

Reset
REQ-024 SHALL, on rst=0 at any time including mid-wait, asynchronously force state=RUN, all counters=0 and wait_err=0.
REQ-025 SHALL hold stall=0, flush=0 and new_pc=0 while rst=0, regardless of inputs.
REQ-026 SHALL resume REQ-008 evaluation on the first posedge after rst rises.

Verification
REQ-027 SHALL cover: stallreq_id=1 for 2 cycles in RUN -> stall=6'b000111 for 2 cycles, stall_cnt=2.
REQ-028 SHALL cover: mem_excepttype=32'h8 with stallreq_ex=1 -> flush=1, stall=0, new_pc=32'h20, then one BLANK cycle ignoring a still-nonzero excepttype, flush_cnt=1.
REQ-029 SHALL cover: mem_excepttype=ERET_TYPE, cp0_epc=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234.
REQ-030 SHALL cover: dcache_busy=1 for 5 cycles with mem_excepttype=32'h8 held -> stall=6'b011111 for 5 cycles and no flush, then flush=1 on the cycle dcache_busy falls.
REQ-031 SHALL cover: icache_busy held 300 cycles with WAIT_LIMIT=255 -> wait_err rises after cycle 256 and stays set after icache_busy falls, stall_cnt=300.
REQ-032 SHALL cover: rst driven low during DCWAIT between clock edges -> stall=0 immediately, counters=0, state RUN after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall, flush with redirect PC,
// cache-wait watchdog and saturating stall/flush event counters.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [31:0] ERET_TYPE  = 32'h0000_000E,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        icache_busy,
   input  logic        dcache_busy,
   input  logic [31:0] mem_excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [15:0] stall_cnt,
   output logic [7:0]  flush_cnt,
   output logic        wait_err
);

   typedef enum logic [1:0] {RUN, ICWAIT, DCWAIT, BLANK} state_t;

   localparam logic [5:0] STALL_DC = 6'b011111;
   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;
   localparam logic [5:0] STALL_IC = 6'b000011;

   state_t      state_q, state_d;
   logic [5:0]  stall_c;
   logic        flush_c;
   logic        exc;
   logic [15:0] wait_cnt, wait_nxt;

   assign exc = (mem_excepttype != 32'h0);

   always_comb begin
      state_d = state_q;
      stall_c = 6'b0;
      flush_c = 1'b0;
      case (state_q)
         // DCWAIT behaves exactly like RUN: its hold is the top-priority row.
         RUN, DCWAIT: begin
            if (dcache_busy) begin
               stall_c = STALL_DC;
               state_d = DCWAIT;
            end else if (exc) begin
               flush_c = 1'b1;
               state_d = BLANK;
            end else if (stallreq_ex) begin
               stall_c = STALL_EX;
               state_d = RUN;
            end else if (stallreq_id) begin
               stall_c = STALL_ID;
               state_d = RUN;
            end else if (icache_busy) begin
               stall_c = STALL_IC;
               state_d = ICWAIT;
            end else begin
               state_d = RUN;
            end
         end
         ICWAIT: begin
            if (dcache_busy) begin
               stall_c = STALL_DC;
               state_d = DCWAIT;
            end else if (exc) begin
               flush_c = 1'b1;
               state_d = BLANK;
            end else begin
               // The fetch hold drops on the cycle the I-cache reports done.
               stall_c = (icache_busy ? STALL_IC : 6'b0)
                       | (stallreq_ex ? STALL_EX : 6'b0)
                       | (stallreq_id ? STALL_ID : 6'b0);
               state_d = icache_busy ? ICWAIT : RUN;
            end
         end
         BLANK: begin
            if (dcache_busy) begin
               stall_c = STALL_DC;
               state_d = DCWAIT;
            end else begin
               state_d = RUN;
            end
         end
      endcase
      if (!rst) begin
         stall_c = 6'b0;
         flush_c = 1'b0;
      end
   end

   assign stall  = stall_c;
   assign flush  = flush_c;
   assign new_pc = !flush_c ? 32'h0 :
                   (mem_excepttype == ERET_TYPE) ? cp0_epc : EXC_VECTOR;

   always_comb begin
      wait_nxt = 16'h0;
      if (state_q == ICWAIT || state_q == DCWAIT)
         wait_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'h1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         stall_cnt <= 16'h0;
         flush_cnt <= 8'h0;
         wait_cnt  <= 16'h0;
         wait_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= wait_nxt;
         if (stall_c != 6'b0 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'h1;
         if (flush_c && flush_cnt != 8'hFF)
            flush_cnt <= flush_cnt + 8'h1;
         if ({16'h0, wait_nxt} > 32'(WAIT_LIMIT))
            wait_err <= 1'b1;
      end
   end

endmodule
